// File: rtl/vc_fifo_bank_pkg.sv
// -----------------------------------------------------------------------------
// vc_fifo_bank_pkg
// Shared definitions for the virtual-channel input buffer and the round-robin
// arbiter stage that pops from it: number of classes, class-id width, default
// word width and FIFO geometry, the class id constants, and a one-hot decoder
// used to steer push/pop strobes onto the per-class FIFOs.
// -----------------------------------------------------------------------------
package vc_fifo_bank_pkg;

  localparam int NUM_VC        = 4;
  localparam int ID_W          = 2;
  localparam int DATA_W_DEF    = 10;
  localparam int DEPTH_DEF     = 4;
  localparam int ADDR_W_DEF    = 2;
  localparam int AF_THRESH_DEF = 3;

  typedef enum logic [ID_W-1:0] {
    VC0 = 2'd0,
    VC1 = 2'd1,
    VC2 = 2'd2,
    VC3 = 2'd3
  } vc_id_e;

  // One-hot strobe for class 'id', all zero when 'en' is low.
  function automatic logic [NUM_VC-1:0] vc_onehot(input logic en, input logic [ID_W-1:0] id);
    logic [NUM_VC-1:0] v;
    v = '0;
    if (en) v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// -----------------------------------------------------------------------------
// vc_fifo_bank_if
// Bundles the producer push channel, the arbiter pop channel and the status
// flags of the virtual-channel FIFO bank.
//   master : producer/arbiter side (drives push/pop, observes data and flags)
//   slave  : the FIFO bank
// Signals:
//   push, push_id, data_in        write strobe, target class, word
//   pop, pop_id                   pop strobe (arbiter valid) and class
//   data_out, data_out_valid      popped word, valid one cycle after the pop
//   empty, full, almost_full      per-class registered flags (bit i = class i)
//   overflow_err, underflow_err   sticky error flags
// -----------------------------------------------------------------------------
interface vc_fifo_bank_if #(
  parameter int DATA_W = vc_fifo_bank_pkg::DATA_W_DEF
) ();
  import vc_fifo_bank_pkg::*;

  logic                 push;
  logic [ID_W-1:0]      push_id;
  logic [DATA_W-1:0]    data_in;
  logic                 pop;
  logic [ID_W-1:0]      pop_id;
  logic [DATA_W-1:0]    data_out;
  logic                 data_out_valid;
  logic [NUM_VC-1:0]    empty;
  logic [NUM_VC-1:0]    full;
  logic [NUM_VC-1:0]    almost_full;
  logic                 overflow_err;
  logic                 underflow_err;

  modport master (
    output push, push_id, data_in, pop, pop_id,
    input  data_out, data_out_valid, empty, full, almost_full,
           overflow_err, underflow_err
  );

  modport slave (
    input  push, push_id, data_in, pop, pop_id,
    output data_out, data_out_valid, empty, full, almost_full,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_bank_sync_fifo_vc.sv
// -----------------------------------------------------------------------------
// sync_fifo_vc
// Single-class circular FIFO used four times inside vc_fifo_bank.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, pop         strobes already decoded for this class
//   data_in           word to store
//   rd_data           word read by the last accepted pop (held otherwise)
//   pop_granted       this cycle's pop is accepted (class not empty)
//   empty, full, almost_full   registered flags from the post-update count
//   overflow_err, underflow_err sticky error flags for this class
// -----------------------------------------------------------------------------
module sync_fifo_vc #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              pop_granted,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow_err,
  output logic              underflow_err
);
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_ovf;
  logic              r_udf;

  logic              w_pop_ok;
  logic              w_push_ok;
  logic [CNT_W-1:0]  w_count_next;

  // A full FIFO still takes a push when the same cycle pops it, because the
  // pop frees the slot the push lands in. An empty FIFO never forwards the
  // incoming word to the output in the same cycle.
  assign w_pop_ok     = pop & ~r_empty;
  assign w_push_ok    = push & (~r_full | w_pop_ok);
  assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CNT_W'(DEPTH));
      r_afull <= (w_count_next >= CNT_W'(AF_THRESH));
      if (push && !w_push_ok) r_ovf <= 1'b1;
      if (pop && !w_pop_ok)   r_udf <= 1'b1;
    end
  end

  assign rd_data       = r_rd_data;
  assign pop_granted   = w_pop_ok;
  assign empty         = r_empty;
  assign full          = r_full;
  assign almost_full   = r_afull;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;
endmodule

// File: rtl/vc_fifo_bank.sv
// -----------------------------------------------------------------------------
// vc_fifo_bank
// Four-class input buffer feeding the round-robin arbiter. Words are stored
// per virtual channel; the arbiter's valid/pop_id pops one word, returned on
// data_out one cycle later with data_out_valid.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    vc_fifo_bank_if.slave: push/pop channels, data_out, flags, errors
// -----------------------------------------------------------------------------
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  vc_fifo_bank_if.slave  bus
);
  logic [NUM_VC-1:0] w_push_vec;
  logic [NUM_VC-1:0] w_pop_vec;
  logic [NUM_VC-1:0] w_pop_granted;
  logic [NUM_VC-1:0] w_empty;
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_afull;
  logic [NUM_VC-1:0] w_ovf;
  logic [NUM_VC-1:0] w_udf;
  logic [DATA_W-1:0] w_rd_data [NUM_VC];

  logic [ID_W-1:0]   r_sel;
  logic              r_valid;

  assign w_push_vec = vc_onehot(bus.push, bus.push_id);
  assign w_pop_vec  = vc_onehot(bus.pop, bus.pop_id);

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      sync_fifo_vc #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .AF_THRESH (AF_THRESH)
      ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (w_push_vec[gi]),
        .pop           (w_pop_vec[gi]),
        .data_in       (bus.data_in),
        .rd_data       (w_rd_data[gi]),
        .pop_granted   (w_pop_granted[gi]),
        .empty         (w_empty[gi]),
        .full          (w_full[gi]),
        .almost_full   (w_afull[gi]),
        .overflow_err  (w_ovf[gi]),
        .underflow_err (w_udf[gi])
      );
    end
  endgenerate

  // The output select only moves on an accepted pop, so data_out keeps showing
  // the last popped word through idle cycles and rejected pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= |w_pop_granted;
      if (|w_pop_granted) r_sel <= bus.pop_id;
    end
  end

  assign bus.data_out       = w_rd_data[r_sel];
  assign bus.data_out_valid = r_valid;
  assign bus.empty          = w_empty;
  assign bus.full           = w_full;
  assign bus.almost_full    = w_afull;
  assign bus.overflow_err   = |w_ovf;
  assign bus.underflow_err  = |w_udf;
endmodule

// File: tb/tb_vc_fifo_bank.sv
module tb_vc_fifo_bank;
  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_fifo_bank_if #(.DATA_W(DW)) bus ();

  vc_fifo_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(2), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of words per class plus expected outputs.
  logic [DW-1:0] mq [0:3][$];
  logic [DW-1:0] m_dout;
  logic          m_dv;
  logic          m_ovf;
  logic          m_udf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_step(input logic ps, input logic [1:0] pid, input logic [DW-1:0] din,
                            input logic pp, input logic [1:0] ppid);
    bit pop_ok, push_ok;
    pop_ok  = pp && (mq[ppid].size() > 0);
    push_ok = ps && ((mq[pid].size() < DEPTH) || (pop_ok && ppid == pid));
    if (pop_ok) begin
      m_dout = mq[ppid].pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    if (pp && !pop_ok) m_udf = 1'b1;
    if (push_ok) mq[pid].push_back(din);
    else if (ps) m_ovf = 1'b1;
  endtask

  task automatic check_all();
    logic [3:0] e, f, a;
    for (int c = 0; c < 4; c++) begin
      e[c] = (mq[c].size() == 0);
      f[c] = (mq[c].size() == DEPTH);
      a[c] = (mq[c].size() >= AF);
    end
    check("data_out_valid", {15'd0, bus.data_out_valid}, {15'd0, m_dv});
    check("data_out", {6'd0, bus.data_out}, {6'd0, m_dout});
    check("empty", {12'd0, bus.empty}, {12'd0, e});
    check("full", {12'd0, bus.full}, {12'd0, f});
    check("almost_full", {12'd0, bus.almost_full}, {12'd0, a});
    check("overflow_err", {15'd0, bus.overflow_err}, {15'd0, m_ovf});
    check("underflow_err", {15'd0, bus.underflow_err}, {15'd0, m_udf});
  endtask

  task automatic step(input logic rst, input logic ps, input logic [1:0] pid,
                      input logic [DW-1:0] din, input logic pp, input logic [1:0] ppid);
    reset       = rst;
    bus.push    = ps;
    bus.push_id = pid;
    bus.data_in = din;
    bus.pop     = pp;
    bus.pop_id  = ppid;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(ps, pid, din, pp, ppid);
    check_all();
  endtask

  task automatic push_only(input logic [1:0] id, input logic [DW-1:0] d);
    step(1'b0, 1'b1, id, d, 1'b0, 2'd0);
  endtask

  task automatic pop_only(input logic [1:0] id);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1, id);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b0; bus.push_id = '0; bus.data_in = '0;
    bus.pop = 1'b0;  bus.pop_id = '0;
    model_reset();

    // 1: reset then idle
    do_reset();
    do_reset();
    idle();
    check("rst_empty", {12'd0, bus.empty}, 16'h000f);
    check("rst_dv", {15'd0, bus.data_out_valid}, 16'h0000);

    // 2: in-order delivery on class 2
    push_only(2'd2, 10'h011);
    push_only(2'd2, 10'h022);
    push_only(2'd2, 10'h033);
    pop_only(2'd2);
    check("t2_w0", {6'd0, bus.data_out}, 16'h0011);
    pop_only(2'd2);
    check("t2_w1", {6'd0, bus.data_out}, 16'h0022);
    pop_only(2'd2);
    check("t2_w2", {6'd0, bus.data_out}, 16'h0033);
    check("t2_empty2", {15'd0, bus.empty[2]}, 16'h0001);

    // 3: fill class 1, overflow, push+pop while full
    push_only(2'd1, 10'h041);
    push_only(2'd1, 10'h042);
    push_only(2'd1, 10'h043);
    check("t3_af1", {15'd0, bus.almost_full[1]}, 16'h0001);
    push_only(2'd1, 10'h044);
    check("t3_full1", {15'd0, bus.full[1]}, 16'h0001);
    push_only(2'd1, 10'h045);
    check("t3_ovf", {15'd0, bus.overflow_err}, 16'h0001);
    step(1'b0, 1'b1, 2'd1, 10'h046, 1'b1, 2'd1);
    check("t3_full_hold", {15'd0, bus.full[1]}, 16'h0001);
    check("t3_head", {6'd0, bus.data_out}, 16'h0041);
    for (int i = 0; i < 4; i++) pop_only(2'd1);
    check("t3_tail", {6'd0, bus.data_out}, 16'h0046);

    // 4: wrap-around on class 0
    do_reset();
    for (int i = 0; i < 4; i++) push_only(2'd0, 10'h100 + 10'(i));
    pop_only(2'd0);
    pop_only(2'd0);
    push_only(2'd0, 10'h104);
    push_only(2'd0, 10'h105);
    pop_only(2'd0);
    check("t4_w2", {6'd0, bus.data_out}, 16'h0102);
    pop_only(2'd0);
    pop_only(2'd0);
    pop_only(2'd0);
    check("t4_w5", {6'd0, bus.data_out}, 16'h0105);

    // 5: pop of empty class 3 with same-cycle push, no fall-through
    do_reset();
    step(1'b0, 1'b1, 2'd3, 10'h3ff, 1'b1, 2'd3);
    check("t5_dv", {15'd0, bus.data_out_valid}, 16'h0000);
    check("t5_udf", {15'd0, bus.underflow_err}, 16'h0001);
    check("t5_empty3", {15'd0, bus.empty[3]}, 16'h0000);
    pop_only(2'd3);
    check("t5_word", {6'd0, bus.data_out}, 16'h03ff);

    // 6: rotating pops with reset in the middle
    do_reset();
    for (int c = 0; c < 4; c++) begin
      push_only(2'(c), 10'h200 + 10'(c));
      push_only(2'(c), 10'h210 + 10'(c));
    end
    pop_only(2'd0);
    pop_only(2'd1);
    step(1'b1, 1'b1, 2'd2, 10'h2aa, 1'b1, 2'd2);
    check("t6_dv", {15'd0, bus.data_out_valid}, 16'h0000);
    check("t6_empty", {12'd0, bus.empty}, 16'h000f);
    pop_only(2'd3);
    check("t6_udf", {15'd0, bus.underflow_err}, 16'h0001);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 60),
           2'($urandom_range(0, 3)),
           10'($urandom),
           ($urandom_range(0, 99) < 50),
           2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
- Four-class input buffer that sits directly upstream of the round-robin arbiter stage (`mid`).
- Stores words per class (virtual channel 0..3) and exports per-class `empty` flags to the arbiter.
- Accepts the arbiter's `valid`/`pop_id` as a pop command and returns the popped word one cycle later.
- Also flags fullness back to the producer.

Parameters:
- DATA_W, 10, width of one stored word.
- DEPTH, 4, entries per class FIFO; must be a power of 2 and at least 2.
- ADDR_W, 2, log2(DEPTH).
- AF_THRESH, 3, occupancy at or above which almost_full[i] asserts.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write strobe from producer.
- push_id  in  2  target class for push.
- data_in  in  DATA_W  word to write.
- pop  in  1  pop strobe; driven by the arbiter's valid.
- pop_id  in  2  class to pop; driven by the arbiter's pop_id.
- data_out  out  DATA_W  popped word, registered.
- data_out_valid  out  1  data_out holds a word popped on the previous cycle.
- empty  out  4  per-class empty flag, bit i = class i.
- full  out  4  per-class full flag (count == DEPTH).
- almost_full  out  4  per-class count >= AF_THRESH.
- overflow_err  out  1  sticky; push to full class without a same-class pop.
- underflow_err  out  1  sticky; pop of an empty class.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. All state is sampled on the rising edge of clk.
- Reset values: all read/write pointers 0, counts 0, empty=4'b1111, full=0, almost_full=0, data_out=0, data_out_valid=0, both error flags 0. Storage array contents are not cleared.
- Each class is an independent circular FIFO.
  - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
  - Count is ADDR_W+1 bits, range 0..DEPTH.
- Flags: empty, full and almost_full are registered and derived from the post-update count. They are valid the cycle after the causing push/pop and are never combinational from inputs.
- Push, accepted when push=1 and class push_id is not full, or when it is full and a pop of the same class occurs in the same cycle:
  - data_in written at wr_ptr; wr_ptr++.
- Push rejected (class full, no same-class pop):
  - word dropped; no state change to that class; overflow_err <= 1.
- Pop, accepted when pop=1 and class pop_id is not empty:
  - data_out <= mem[rd_ptr]; data_out_valid <= 1; rd_ptr++. Latency 1 cycle.
- Pop rejected (class empty):
  - data_out_valid <= 0; data_out holds previous value; underflow_err <= 1.
  - A same-cycle push to that empty class still proceeds; no fall-through.
- When pop=0: data_out_valid <= 0 and data_out holds its value.
- Simultaneous push and pop:
  - Different classes: both proceed independently.
  - Same class, non-empty and not full: count unchanged, both pointers advance.
  - Same class, full: both proceed, count stays DEPTH.
  - Same class, empty: push only, underflow_err set.
- Error flags are sticky until reset.
- Reset asserted mid-stream wins over any same-cycle push/pop: in-flight words are discarded, and data_out_valid is 0 in the cycle after reset.
- Throughput: one push and one pop per cycle sustained.

Decomposition:
- Shared package/include holds: NUM_VC=4, ID_W=2, DATA_W default, and the class id constants VC0..VC3. The arbiter stage uses the same package.
- Natural sub-module: `sync_fifo_vc`, a single-class FIFO with push/pop/data/count/empty/full/almost_full and a "pop_granted" output.
  - The bank instantiates it 4x.
  - Push and pop are decoded onto the 4 instances by id.
  - data_out is muxed by a registered copy of pop_id.
  - The error flags are OR-reduced across the instances.

Test Plan:
1. Reset then idle -> empty=4'b1111, full=0, data_out_valid=0, both error flags 0.
2. Push 0x011,0x022,0x033 to class 2, then pop class 2 three times on consecutive cycles -> data_out 0x011,0x022,0x033 on the cycles after each pop with data_out_valid=1; empty[2] returns to 1 after the third pop.
3. Push 4 words to class 1 -> almost_full[1]=1 after the 3rd, full[1]=1 after the 4th. A 5th push alone -> dropped, overflow_err=1. A push and pop of class 1 in the same cycle while full -> accepted, full[1] stays 1, FIFO order preserved.
4. Fill class 0 with 0x100..0x103, pop 2, push 0x104,0x105 (wrap-around), pop 4 -> output 0x102,0x103,0x104,0x105.
5. Pop class 3 while empty with a simultaneous push of 0x3FF to class 3 -> data_out_valid=0, underflow_err=1, empty[3]=0 next cycle; the next pop returns 0x3FF.
6. Drive the arbiter-style rotating pop_id 0,1,2,3 with all classes loaded, assert reset in the middle of the sequence -> next cycle all flags at reset values and data_out_valid=0; subsequent pops set underflow_err.
